// File: rtl/ecc_scrub_pkg.sv
// Shared types and constants for the ECC scrub controller.
// Holds the FSM state enum, the decoder error_type bit positions and the
// read tag carried alongside each issued read.
package ecc_scrub_pkg;

    // Scrubber FSM states. StWb is only reachable when ECC_SCRUB_WB_EN is defined.
    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StIssue,
        StResp,
        StWb,
        StNext
    } scrub_state_e;

    // Bit positions inside dec_error_type.
    localparam int unsigned ERR_SEC_BIT = 0;
    localparam int unsigned ERR_DED_BIT = 1;

    // Tag travelling with each read so the response can be routed.
    typedef struct packed {
        logic valid;
        logic is_scrub;
    } scrub_tag_t;

endpackage

// File: rtl/ecc_scrub_tag_pipe.sv
// Tag shift register matching the decoder read latency.
// The head entry lines up with dec_data_valid for the read issued
// RD_LATENCY cycles earlier.
module ecc_scrub_tag_pipe
    import ecc_scrub_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  scrub_tag_t tag_in,
    output scrub_tag_t tag_head
);

    scrub_tag_t pipe_q [RD_LATENCY];

    // Shift one stage per cycle; reset empties every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_in;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_head = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background ECC scrubber and read-port arbiter.
// Host reads always win the shared read path; the scrubber walks word
// addresses 0..scrub_last_addr with a programmable gap between reads.
// Optional feature macro: ECC_SCRUB_WB_EN enables corrected write-back of
// single-bit errors; without it errors are only counted.
module ecc_scrub_ctrl
    import ecc_scrub_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  ecc_scrub_clk,
    input  logic                  ecc_scrub_rst,
    input  logic                  ecc_scrub_sw_rst,
    input  logic                  scrub_en,
    input  logic [31:0]           scrub_interval,
    input  logic [ADDR_WIDTH-3:0] scrub_last_addr,
    input  logic                  host_rd_req,
    input  logic [ADDR_WIDTH-3:0] host_rd_addr,
    output logic                  host_rd_gnt,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-3:0] rd_addr_o,
    input  logic                  dec_data_valid,
    input  logic [DATA_WIDTH-1:0] dec_rd_data,
    input  logic [31:0]           dec_error_type,
    output logic                  host_data_valid,
    output logic                  wb_en_o,
    output logic [ADDR_WIDTH-3:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    input  logic                  wb_ack_i,
    output logic                  scrub_busy,
    output logic                  scrub_pass_done,
    output logic [CNT_WIDTH-1:0]  sec_count,
    output logic [CNT_WIDTH-1:0]  ded_count
);

    localparam int unsigned WordAw = ADDR_WIDTH - 2;

    logic                 soft_rst;
    logic                 scrub_issue;
    logic                 scrub_resp;
    logic                 sec_hit;
    logic                 ded_hit;
    scrub_tag_t           tag_in;
    scrub_tag_t           tag_head;

    scrub_state_e         state_q, state_d;
    logic [WordAw-1:0]    addr_q, addr_d;
    logic [31:0]          timer_q, timer_d;
    logic [CNT_WIDTH-1:0] sec_q, sec_d;
    logic [CNT_WIDTH-1:0] ded_q, ded_d;

    // Bits 31:2 of the error type carry no meaning for the scrubber.
    logic unused_err_bits;
    assign unused_err_bits = ^dec_error_type[31:2];

    assign soft_rst = ecc_scrub_rst | ecc_scrub_sw_rst;

    // Combinational arbitration: host first, scrubber only in host-free cycles.
    always_comb begin
        host_rd_gnt = 1'b0;
        scrub_issue = 1'b0;
        if (!soft_rst) begin
            host_rd_gnt = host_rd_req;
            scrub_issue = !host_rd_req && (state_q == StIssue);
        end
        rd_en_o   = host_rd_gnt | scrub_issue;
        rd_addr_o = host_rd_req ? host_rd_addr : addr_q;
    end

    assign tag_in = '{valid: rd_en_o, is_scrub: scrub_issue};

    ecc_scrub_tag_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_tag_pipe (
        .clk      (ecc_scrub_clk),
        .rst      (soft_rst),
        .tag_in   (tag_in),
        .tag_head (tag_head)
    );

    // Responses are routed by the tag head; an empty head drops the response.
    always_comb begin
        host_data_valid = !soft_rst && dec_data_valid && tag_head.valid && !tag_head.is_scrub;
        scrub_resp      = dec_data_valid && tag_head.valid && tag_head.is_scrub;
        sec_hit         = dec_error_type[ERR_SEC_BIT] && !dec_error_type[ERR_DED_BIT];
        ded_hit         = dec_error_type[ERR_DED_BIT];
    end

`ifdef ECC_SCRUB_WB_EN
    logic [WordAw-1:0]     wb_addr_q, wb_addr_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
`else
    logic unused_wb;
    assign unused_wb = ^{dec_rd_data, wb_ack_i};
`endif

    // Scrub walk sequencing, error counting and write-back capture.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        timer_d = '0;
        sec_d   = sec_q;
        ded_d   = ded_q;
`ifdef ECC_SCRUB_WB_EN
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (scrub_en) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // Compared against the live interval so a new value applies at once.
                if (timer_q >= scrub_interval) begin
                    state_d = StIssue;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            StIssue: begin
                if (!host_rd_req) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (scrub_resp) begin
                    state_d = StNext;
                    if (ded_hit) begin
                        if (ded_q != {CNT_WIDTH{1'b1}}) begin
                            ded_d = ded_q + CNT_WIDTH'(1);
                        end
                    end else if (sec_hit) begin
                        if (sec_q != {CNT_WIDTH{1'b1}}) begin
                            sec_d = sec_q + CNT_WIDTH'(1);
                        end
`ifdef ECC_SCRUB_WB_EN
                        wb_addr_d = addr_q;
                        wb_data_d = dec_rd_data;
                        state_d   = StWb;
`endif
                    end
                end
            end
`ifdef ECC_SCRUB_WB_EN
            StWb: begin
                if (wb_ack_i) begin
                    state_d = StNext;
                end
            end
`endif
            StNext: begin
                if (addr_q == scrub_last_addr) begin
                    addr_d = '0;
                end else begin
                    addr_d = addr_q + WordAw'(1);
                end
                state_d = scrub_en ? StWait : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; either reset source abandons any in-flight work.
    always_ff @(posedge ecc_scrub_clk) begin
        if (soft_rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            timer_q <= '0;
            sec_q   <= '0;
            ded_q   <= '0;
`ifdef ECC_SCRUB_WB_EN
            wb_addr_q <= '0;
            wb_data_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            timer_q <= timer_d;
            sec_q   <= sec_d;
            ded_q   <= ded_d;
`ifdef ECC_SCRUB_WB_EN
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
`endif
        end
    end

    // Status and write-back outputs derived from registered state.
    always_comb begin
        scrub_busy      = (state_q != StIdle);
        scrub_pass_done = (state_q == StNext) && (addr_q == scrub_last_addr);
        sec_count       = sec_q;
        ded_count       = ded_q;
`ifdef ECC_SCRUB_WB_EN
        wb_en_o   = (state_q == StWb);
        wb_addr_o = wb_addr_q;
        wb_data_o = wb_data_q;
`else
        wb_en_o   = 1'b0;
        wb_addr_o = '0;
        wb_data_o = '0;
`endif
    end

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Self-checking bench for ecc_scrub_ctrl: directed scenarios plus a
// randomized run, all compared cycle by cycle with a behavioural model.
module tb_ecc_scrub_ctrl;

    localparam int unsigned AW      = 14;
    localparam int unsigned WAW     = AW - 2;
    localparam int unsigned DW      = 32;
    localparam int unsigned LAT     = 1;
    localparam int unsigned CW      = 6;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    // Model phases of the scrub walk.
    localparam int P_IDLE  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_ISSUE = 2;
    localparam int P_RESP  = 3;
    localparam int P_WB    = 4;
    localparam int P_NEXT  = 5;

    logic           clk = 1'b0;
    logic           rst, sw_rst, scrub_en;
    logic [31:0]    interval;
    logic [WAW-1:0] last_addr, haddr;
    logic           hreq, dvalid, ack;
    logic [DW-1:0]  ddata;
    logic [31:0]    derr;

    logic           gnt, rd_en, hdv, wb_en, busy, pass_done;
    logic [WAW-1:0] rd_addr, wb_addr;
    logic [DW-1:0]  wb_data;
    logic [CW-1:0]  sec, ded;

    always #5 clk = ~clk;

    ecc_scrub_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_LATENCY (LAT),
        .CNT_WIDTH  (CW)
    ) dut (
        .ecc_scrub_clk    (clk),
        .ecc_scrub_rst    (rst),
        .ecc_scrub_sw_rst (sw_rst),
        .scrub_en         (scrub_en),
        .scrub_interval   (interval),
        .scrub_last_addr  (last_addr),
        .host_rd_req      (hreq),
        .host_rd_addr     (haddr),
        .host_rd_gnt      (gnt),
        .rd_en_o          (rd_en),
        .rd_addr_o        (rd_addr),
        .dec_data_valid   (dvalid),
        .dec_rd_data      (ddata),
        .dec_error_type   (derr),
        .host_data_valid  (hdv),
        .wb_en_o          (wb_en),
        .wb_addr_o        (wb_addr),
        .wb_data_o        (wb_data),
        .wb_ack_i         (ack),
        .scrub_busy       (busy),
        .scrub_pass_done  (pass_done),
        .sec_count        (sec),
        .ded_count        (ded)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=0x%0h expected=0x%0h", tag, $time, got, exp);
        end
    endtask

    // Behavioural model state.
    int             ph;
    logic [WAW-1:0] m_addr;
    int unsigned    m_elapsed, m_sec, m_ded;
    logic [WAW-1:0] m_wba;
    logic [DW-1:0]  m_wbd;
    int             m_pass;
    bit [1:0]       tagq[$];     // {valid, is_scrub}, front = oldest
    bit             e_gnt, e_issue, e_rd;

    // Stimulus knobs.
    int  err_mode;   // <0 random, else fixed error type
    int  ack_pct;
    bit  spurious;
    bit  force_data;
    int  cyc;
    int  obs_pass;
    bit  track_gap;
    int  last_issue_cyc;
    int  min_gap;
    int  scrub_reads_seen;
    bit  last_hdv;

    task automatic model_reset();
        ph        = P_IDLE;
        m_addr    = '0;
        m_elapsed = 0;
        m_sec     = 0;
        m_ded     = 0;
        m_wba     = '0;
        m_wbd     = '0;
        tagq.delete();
        for (int i = 0; i < LAT; i++) tagq.push_back(2'b00);
    endtask

    task automatic model_update(input bit [1:0] head);
        if (rst || sw_rst) begin
            model_reset();
            return;
        end
        case (ph)
            P_IDLE: if (scrub_en) begin ph = P_WAIT; m_elapsed = 0; end
            P_WAIT: if (m_elapsed >= interval) ph = P_ISSUE; else m_elapsed++;
            P_ISSUE: if (!hreq) ph = P_RESP;
            P_RESP: begin
                if (dvalid && head == 2'b11) begin
                    ph = P_NEXT;
                    if (derr[1]) begin
                        if (m_ded < CNT_MAX) m_ded++;
                    end else if (derr[0]) begin
                        if (m_sec < CNT_MAX) m_sec++;
`ifdef ECC_SCRUB_WB_EN
                        m_wba = m_addr;
                        m_wbd = ddata;
                        ph    = P_WB;
`endif
                    end
                end
            end
            P_WB: if (ack) ph = P_NEXT;
            P_NEXT: begin
                if (m_addr == last_addr) begin
                    m_addr = '0;
                    m_pass++;
                end else begin
                    m_addr = m_addr + WAW'(1);
                end
                ph        = scrub_en ? P_WAIT : P_IDLE;
                m_elapsed = 0;
            end
            default: ph = P_IDLE;
        endcase
        void'(tagq.pop_front());
        tagq.push_back({e_rd, e_issue});
    endtask

    // One clock cycle: drive decoder side, compare outputs, advance the model.
    task automatic step();
        bit [1:0] head;
        bit       r;
        head   = tagq[0];
        dvalid = head[1] | (spurious && ($urandom_range(0, 9) == 0));
        ddata  = force_data ? 32'hDEADBEEF : $urandom();
        derr   = (err_mode < 0) ? 32'($urandom_range(0, 3)) : 32'(err_mode);
        ack    = ($urandom_range(0, 99) < ack_pct);
        #2;
        r       = rst | sw_rst;
        e_gnt   = !r && hreq;
        e_issue = !r && !hreq && (ph == P_ISSUE);
        e_rd    = e_gnt | e_issue;
        check_eq("rd_en", rd_en, e_rd);
        if (e_rd) check_eq("rd_addr", rd_addr, hreq ? haddr : m_addr);
        check_eq("host_gnt", gnt, e_gnt);
        check_eq("host_data_valid", hdv, !r && dvalid && head == 2'b10);
        check_eq("busy", busy, ph != P_IDLE);
        check_eq("pass_done", pass_done, (ph == P_NEXT) && (m_addr == last_addr));
        check_eq("wb_en", wb_en, ph == P_WB);
`ifdef ECC_SCRUB_WB_EN
        if (ph == P_WB) begin
            check_eq("wb_addr", wb_addr, m_wba);
            check_eq("wb_data", wb_data, m_wbd);
        end
`else
        check_eq("wb_addr_tied", wb_addr, 0);
        check_eq("wb_data_tied", wb_data, 0);
`endif
        check_eq("sec_count", sec, m_sec);
        check_eq("ded_count", ded, m_ded);
        last_hdv = hdv;
        if (pass_done) obs_pass++;
        if (track_gap && rd_en && !hreq) begin
            scrub_reads_seen++;
            if (last_issue_cyc >= 0 && (cyc - last_issue_cyc) < min_gap) begin
                min_gap = cyc - last_issue_cyc;
            end
            last_issue_cyc = cyc;
        end
        @(posedge clk);
        model_update(head);
        cyc++;
        #1;
    endtask

    task automatic wait_phase(input int target, input string tag);
        int n = 0;
        while (ph != target && n < 300) begin
            step();
            n++;
        end
        check_eq(tag, ph == target, 1'b1);
    endtask

    task automatic wait_issue_at(input logic [WAW-1:0] a, input string tag);
        int n = 0;
        while (!(ph == P_ISSUE && m_addr == a) && n < 500) begin
            step();
            n++;
        end
        check_eq(tag, (ph == P_ISSUE) && (m_addr == a), 1'b1);
    endtask

    initial begin
        rst = 1'b1; sw_rst = 1'b0; scrub_en = 1'b0; interval = 32'd4; last_addr = WAW'(3);
        hreq = 1'b0; haddr = '0; dvalid = 1'b0; ddata = '0; derr = '0; ack = 1'b0;
        err_mode = 0; ack_pct = 50; spurious = 1'b0; force_data = 1'b0;
        cyc = 0; obs_pass = 0; m_pass = 0; track_gap = 1'b0; last_issue_cyc = -1;
        min_gap = 1000; scrub_reads_seen = 0; last_hdv = 1'b0;
        e_gnt = 1'b0; e_issue = 1'b0; e_rd = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        check_eq("reset_busy", busy, 0);
        check_eq("reset_sec", sec, 0);
        check_eq("reset_ded", ded, 0);
        check_eq("reset_wb_en", wb_en, 0);

        // Clean walk over 0..3 with interval 4: one pass, no errors.
        scrub_en  = 1'b1;
        track_gap = 1'b1;
        repeat (50) step();
        track_gap = 1'b0;
        check_eq("walk_pass_count", obs_pass, 1);
        check_eq("walk_model_pass", m_pass, 1);
        check_eq("walk_reads", scrub_reads_seen >= 5, 1'b1);
        check_eq("walk_spacing", min_gap >= 5, 1'b1);
        check_eq("walk_sec", sec, 0);
        check_eq("walk_ded", ded, 0);

        // Host holds the port for 20 cycles while a scrub read is pending.
        wait_phase(P_ISSUE, "reach_issue_hold");
        scrub_reads_seen = 0;
        track_gap = 1'b1;
        hreq = 1'b1;
        repeat (20) begin
            haddr = WAW'($urandom());
            step();
        end
        check_eq("hold_no_scrub", scrub_reads_seen, 0);
        hreq = 1'b0;
        step();
        track_gap = 1'b0;
        check_eq("hold_scrub_after", scrub_reads_seen, 1);

        // Single-bit error at word 5, ack withheld for 3 cycles.
        last_addr = WAW'(7);
        interval  = 32'd0;
        wait_issue_at(WAW'(5), "reach_addr5");
        err_mode = 1; force_data = 1'b1; ack_pct = 0;
        step();
        step();
        err_mode = 0; force_data = 1'b0;
`ifdef ECC_SCRUB_WB_EN
        repeat (3) begin
            check_eq("wb_hold_en", wb_en, 1);
            check_eq("wb_hold_addr", wb_addr, 5);
            check_eq("wb_hold_data", wb_data, 32'hDEADBEEF);
            step();
        end
        ack_pct = 100;
        step();
        check_eq("wb_released", wb_en, 0);
`endif
        check_eq("sec_after_single", sec, 1);

        // Double-bit error: counted, never written back.
        wait_issue_at(WAW'(6), "reach_addr6");
        err_mode = 2;
        step();
        step();
        err_mode = 0;
        check_eq("ded_after_double", ded, 1);
        check_eq("ded_no_wb", wb_en, 0);
        check_eq("sec_unchanged", sec, 1);

        // Host read right behind a scrub read: responses routed in order.
        wait_phase(P_ISSUE, "reach_issue_route");
        step();
        hreq = 1'b1; haddr = WAW'(9);
        step();
        check_eq("route_scrub_resp", last_hdv, 0);
        hreq = 1'b0;
        step();
        check_eq("route_host_resp", last_hdv, 1);

        // Randomized traffic.
        err_mode = -1; ack_pct = 40; spurious = 1'b1;
        last_addr = WAW'($urandom_range(2, 9));
        repeat (3000) begin
            hreq  = ($urandom_range(0, 99) < 30);
            haddr = WAW'($urandom());
            if ($urandom_range(0, 149) == 0) scrub_en = !scrub_en;
            if ($urandom_range(0, 99) == 0) interval = 32'($urandom_range(0, 6));
            sw_rst = ($urandom_range(0, 499) == 0);
            step();
        end
        sw_rst = 1'b0; hreq = 1'b0; spurious = 1'b0;

        // Saturation of both counters.
        scrub_en = 1'b1; interval = 32'd0; ack_pct = 100;
        err_mode = 1;
        repeat (500) step();
        check_eq("sec_saturated", sec, CNT_MAX);
        err_mode = 2;
        repeat (500) step();
        check_eq("ded_saturated", ded, CNT_MAX);
        check_eq("sec_still_sat", sec, CNT_MAX);

        // Reset while a scrub operation is in flight.
        err_mode = 1; ack_pct = 0;
`ifdef ECC_SCRUB_WB_EN
        wait_phase(P_WB, "reach_wb_for_reset");
        step();
`else
        wait_phase(P_RESP, "reach_resp_for_reset");
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        err_mode = 0;
        check_eq("rst_wb_en", wb_en, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_sec", sec, 0);
        check_eq("rst_ded", ded, 0);
        wait_phase(P_ISSUE, "reach_issue_after_reset");
        check_eq("rst_scrub_addr", rd_addr, 0);
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
